// File: rtl/deser_lane_arbiter_if.sv
// Word-level bundle between the serial lane front ends, the deserializer
// arbiter and the word consumer.
//   req_i/data_i/data_val_i : per-lane request, serial bit and bit-valid
//   gnt_o                   : one-hot grant back to the lanes
//   word_o/word_lane_o      : deserialized word and its source lane
//   word_val_o/word_rdy_i   : word valid/ready handshake
//   abort_o                 : burst aborted pulse
// The master modport is the lane/consumer side; the slave modport is the arbiter.
interface deser_lane_arbiter_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0] req_i;
    logic [LANES-1:0] data_i;
    logic [LANES-1:0] data_val_i;
    logic [LANES-1:0] gnt_o;
    logic [WIDTH-1:0] word_o;
    logic [IDX_W-1:0] word_lane_o;
    logic             word_val_o;
    logic             word_rdy_i;
    logic             abort_o;

    modport master (
        output req_i, data_i, data_val_i, word_rdy_i,
        input  gnt_o, word_o, word_lane_o, word_val_o, abort_o
    );

    modport slave (
        input  req_i, data_i, data_val_i, word_rdy_i,
        output gnt_o, word_o, word_lane_o, word_val_o, abort_o
    );
endinterface

// File: rtl/deser_lane_arbiter.sv
// Round-robin shared serial-to-parallel deserializer.
// One of LANES serial requesters is granted per word; its bits are shifted in
// MSB first and the finished word is offered on a valid/ready output along
// with the lane index.
// Ports:
//   clk_i    : clock, rising edge
//   arst_n_i : asynchronous reset, active-low
//   bus      : deser_lane_arbiter_if.slave (request/serial inputs, grant,
//              word handshake, abort pulse)
// Optional feature: define DESER_ARB_TIMEOUT_EN to abort a burst after
// TIMEOUT_CYCLES consecutive cycles without a valid bit from the granted lane.
module deser_lane_arbiter #(
    parameter int unsigned LANES          = 4,
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    deser_lane_arbiter_if.slave   bus
);
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Elaboration-time parameter range check
    if (LANES < 2 || LANES > 16 || WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("deser_lane_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

    state_e           state_q,      state_d;
    logic [LANES-1:0] gnt_q,        gnt_d;
    logic [IDX_W-1:0] gidx_q,       gidx_d;
    logic [IDX_W-1:0] rr_q,         rr_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [WIDTH-1:0] shift_q,      shift_d;
    logic [WIDTH-1:0] word_q,       word_d;
    logic [IDX_W-1:0] word_lane_q,  word_lane_d;
    logic             word_val_q,   word_val_d;

    logic [IDX_W-1:0] sel_c;
    logic             any_req_c;
    logic             bit_val_c;
    logic             bit_dat_c;

`ifdef DESER_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]  idle_q,       idle_d;
    logic             abort_q,      abort_d;
`endif

    // Round-robin pick: first requesting lane at or after the pointer
    always_comb begin
        int unsigned j;
        j         = 0;
        sel_c     = '0;
        any_req_c = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            j = 32'(rr_q) + i;
            if (j >= LANES) begin
                j = j - LANES;
            end
            if (!any_req_c && bus.req_i[IDX_W'(j)]) begin
                any_req_c = 1'b1;
                sel_c     = IDX_W'(j);
            end
        end
    end

    assign bit_val_c = bus.data_val_i[gidx_q];
    assign bit_dat_c = bus.data_i[gidx_q];

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gidx_d      = gidx_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        word_d      = word_q;
        word_lane_d = word_lane_q;
        word_val_d  = word_val_q;
`ifdef DESER_ARB_TIMEOUT_EN
        idle_d      = idle_q;
        abort_d     = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (any_req_c) begin
                    state_d        = ST_SHIFT;
                    gnt_d          = '0;
                    gnt_d[sel_c]   = 1'b1;
                    gidx_d         = sel_c;
                    cnt_d          = CNT_W'(WIDTH - 1);
                    rr_d           = (sel_c == IDX_W'(LANES - 1)) ? '0 : IDX_W'(sel_c + 1'b1);
`ifdef DESER_ARB_TIMEOUT_EN
                    idle_d         = '0;
`endif
                end
            end
            ST_SHIFT: begin
                if (bit_val_c) begin
                    shift_d[cnt_q] = bit_dat_c;
`ifdef DESER_ARB_TIMEOUT_EN
                    idle_d         = '0;
`endif
                    if (cnt_q == '0) begin
                        // Last bit: publish the completed word next cycle
                        state_d     = ST_OUT;
                        gnt_d       = '0;
                        word_d      = shift_d;
                        word_lane_d = gidx_q;
                        word_val_d  = 1'b1;
                        cnt_d       = CNT_W'(WIDTH - 1);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`ifdef DESER_ARB_TIMEOUT_EN
                else if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // Granted lane went silent too long: drop the partial word
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    idle_d  = '0;
                    abort_d = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
`endif
            end
            ST_OUT: begin
                if (bus.word_rdy_i) begin
                    state_d    = ST_IDLE;
                    word_val_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gidx_q      <= '0;
            rr_q        <= '0;
            cnt_q       <= CNT_W'(WIDTH - 1);
            shift_q     <= '0;
            word_q      <= '0;
            word_lane_q <= '0;
            word_val_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gidx_q      <= gidx_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            word_lane_q <= word_lane_d;
            word_val_q  <= word_val_d;
        end
    end

`ifdef DESER_ARB_TIMEOUT_EN
    // Timeout counter and abort pulse
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            idle_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            idle_q  <= idle_d;
            abort_q <= abort_d;
        end
    end

    assign bus.abort_o = abort_q;
`else
    assign bus.abort_o = 1'b0;
`endif

    assign bus.gnt_o       = gnt_q;
    assign bus.word_o      = word_q;
    assign bus.word_lane_o = word_lane_q;
    assign bus.word_val_o  = word_val_q;

endmodule

// File: tb/tb_deser_lane_arbiter.sv
// Directed + randomized bench for deser_lane_arbiter (LANES=4, WIDTH=16).
// A transaction-level model tracks the round-robin pointer as a plain integer;
// the expected word is the bit pattern the bench itself drives on the
// granted lane.
module tb_deser_lane_arbiter;
    localparam int unsigned LANES = 4;
    localparam int unsigned WIDTH = 16;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   rr_m;

    deser_lane_arbiter_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

    deser_lane_arbiter #(.LANES(LANES), .WIDTH(WIDTH), .TIMEOUT_CYCLES(64)) dut (
        .clk_i    (clk),
        .arst_n_i (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: first requesting lane at or after the pointer, then advance
    function automatic logic [1:0] pick(input logic [3:0] req);
        for (int i = 0; i < 4; i++) begin
            int j;
            j = (rr_m + i) % 4;
            if (req[j]) begin
                rr_m = (j + 1) % 4;
                return 2'(j);
            end
        end
        return 2'd0;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] l);
        logic [3:0] v;
        v    = '0;
        v[l] = 1'b1;
        return v;
    endfunction

    // Random activity on every lane, granted lane's valid forced low
    task automatic garbage(input logic [1:0] lane);
        bus.data_i             = 4'($urandom);
        bus.data_val_i         = 4'($urandom);
        bus.data_val_i[lane]   = 1'b0;
    endtask

    task automatic send_bit(input logic [1:0] lane, input logic b, input int max_gap);
        int gaps;
        gaps = int'($urandom_range(max_gap, 0));
        repeat (gaps) begin
            garbage(lane);
            step();
        end
        garbage(lane);
        bus.data_val_i[lane] = 1'b1;
        bus.data_i[lane]     = b;
        step();
    endtask

    task automatic stall(input logic [1:0] lane, input int n);
        repeat (n) begin
            garbage(lane);
            step();
        end
    endtask

    task automatic grant(input logic [3:0] req, output logic [1:0] lane);
        lane       = pick(req);
        bus.req_i  = req;
        step();
        check("gnt", 32'(bus.gnt_o), 32'(onehot(lane)));
        check("val_in_shift", 32'(bus.word_val_o), 32'd0);
    endtask

    task automatic finish_word(input logic [1:0] lane, input logic [15:0] w, input int hold);
        check("word_val", 32'(bus.word_val_o), 32'd1);
        check("word", 32'(bus.word_o), 32'(w));
        check("word_lane", 32'(bus.word_lane_o), 32'(lane));
        check("gnt_out", 32'(bus.gnt_o), 32'd0);
        bus.word_rdy_i = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_val", 32'(bus.word_val_o), 32'd1);
            check("hold_word", 32'({bus.word_lane_o, bus.word_o}), 32'({lane, w}));
            check("hold_gnt", 32'(bus.gnt_o), 32'd0);
        end
        bus.word_rdy_i = 1'b1;
        step();
        check("val_after_hs", 32'(bus.word_val_o), 32'd0);
        bus.word_rdy_i = 1'b0;
    endtask

    task automatic do_word(input logic [3:0] req, input logic [15:0] w, input int max_gap, input int hold);
        logic [1:0] lane;
        grant(req, lane);
        for (int b = 15; b >= 0; b--) begin
            send_bit(lane, w[b], max_gap);
            if (b == 1) begin
                check("gnt_mid", 32'(bus.gnt_o), 32'(onehot(lane)));
                check("val_mid", 32'(bus.word_val_o), 32'd0);
            end
        end
        finish_word(lane, w, hold);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        rr_m  = 0;
    endtask

    initial begin
        logic [1:0]  lane;
        logic [3:0]  r;
        logic [15:0] w;
        total          = 0;
        bad            = 0;
        rr_m           = 0;
        rst_n          = 1'b0;
        bus.req_i      = '0;
        bus.data_i     = '0;
        bus.data_val_i = '0;
        bus.word_rdy_i = 1'b0;

        // Reset values
        step();
        step();
        check("rst_gnt", 32'(bus.gnt_o), 32'd0);
        check("rst_val", 32'(bus.word_val_o), 32'd0);
        check("rst_word", 32'(bus.word_o), 32'd0);
        check("rst_lane", 32'(bus.word_lane_o), 32'd0);
        check("rst_abort", 32'(bus.abort_o), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_no_req_gnt", 32'(bus.gnt_o), 32'd0);
        bus.word_rdy_i = 1'b1;
        step();
        check("rdy_no_val", 32'(bus.word_val_o), 32'd0);
        bus.word_rdy_i = 1'b0;

        // Single lane 1, no gaps
        do_word(4'b0010, 16'hA5C3, 0, 0);
        do_word(4'b0010, 16'h3C5A, 0, 1);

        // All lanes requesting from a fresh pointer: order 0,1,2,3,0
        do_reset();
        for (int k = 0; k < 5; k++) begin
            logic [1:0] l;
            l = 2'(k % 4);
            do_word(4'b1111, {4{2'b00, l}}, 0, 0);
        end

        // Lane 2 with gaps while other lanes toggle garbage
        do_word(4'b0100, 16'hBEEF, 3, 0);
        do_word(4'b0100, 16'($urandom), 4, 0);

        // Back-pressure with everybody requesting
        do_word(4'b1111, 16'h1234, 1, 10);

`ifndef DESER_ARB_TIMEOUT_EN
        // Long silence from the granted lane never aborts
        grant(4'b1000, lane);
        w = 16'hC0DE;
        for (int b = 15; b >= 11; b--) send_bit(lane, w[b], 0);
        stall(lane, 80);
        check("no_abort", 32'(bus.abort_o), 32'd0);
        check("gnt_hold_stall", 32'(bus.gnt_o), 32'(onehot(lane)));
        for (int b = 10; b >= 0; b--) send_bit(lane, w[b], 0);
        finish_word(lane, w, 0);
`endif

        // Randomized words
        for (int k = 0; k < 10; k++) begin
            r = 4'($urandom);
            if (r == 4'd0) r = 4'b0001;
            do_word(r, 16'($urandom), int'($urandom_range(2, 0)), int'($urandom_range(3, 0)));
        end

        // Reset mid-burst after 7 bits
        grant(4'b0110, lane);
        for (int b = 0; b < 7; b++) send_bit(lane, 1'($urandom), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(bus.gnt_o), 32'd0);
        check("mid_rst_val", 32'(bus.word_val_o), 32'd0);
        check("mid_rst_word", 32'(bus.word_o), 32'd0);
        check("mid_rst_lane", 32'(bus.word_lane_o), 32'd0);
        bus.req_i = 4'b0000;
        step();
        rst_n = 1'b1;
        rr_m  = 0;
        do_word(4'b1111, 16'h0F0F, 0, 0);

`ifdef DESER_ARB_TIMEOUT_EN
        // Timeout: lane 0 sends 5 bits then goes quiet
        do_reset();
        grant(4'b0011, lane);
        for (int b = 0; b < 5; b++) send_bit(lane, 1'b1, 0);
        stall(lane, 63);
        check("abort_early", 32'(bus.abort_o), 32'd0);
        stall(lane, 1);
        check("abort_pulse", 32'(bus.abort_o), 32'd1);
        check("abort_gnt", 32'(bus.gnt_o), 32'd0);
        check("abort_val", 32'(bus.word_val_o), 32'd0);
        lane = pick(4'b0011);
        step();
        check("abort_clear", 32'(bus.abort_o), 32'd0);
        check("gnt_after_abort", 32'(bus.gnt_o), 32'(onehot(lane)));
        check("lane_after_abort", 32'(lane), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard against a stuck run
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
